uart_rx_fifo: RTL and testbench

//   8N1 UART receiver with a byte FIFO; the serial front end of the UART-to-AHB bridge.

---
 rtl/uart_rx_fifo_pkg.sv | 19 +
 rtl/uart_byte_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path:
// FSM state encodings, bit timing constants and a 2-of-3 vote helper.
package uart_rx_fifo_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BRK   = 3'd4;

    localparam int UART_TICKS_PER_BIT = 16;
    localparam int UART_MID_TICK      = 7;
    localparam int UART_DATA_BITS     = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_byte_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic [FIFO_AW:0] level,
    output logic             drop
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_q;
    logic [FIFO_AW:0] wr_d;
    logic [FIFO_AW:0] rd_q;
    logic [FIFO_AW:0] rd_d;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    // Flag, handshake and next-pointer decode.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                  (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        drop    = push && !push_ok;
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
        level   = wr_q - rd_q;
        rd_data = mem_q[rd_q[FIFO_AW-1:0]];
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[FIFO_AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO (bridge serial front end).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at ticks 6/7/8.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int FIFO_AW  = 3
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             RX,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [FIFO_AW:0] level,
    output logic             frame_err,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             rx_busy
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int TW = $clog2(UART_TICKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);

    localparam logic [PW-1:0] P_LAST   = PW'(PRESCALE);
    localparam logic [TW-1:0] T_LAST   = TW'(UART_TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_MID    = TW'(UART_MID_TICK);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
    // Vote completes on the third sample; bit-end moves stay at T_LAST.
    localparam logic [TW-1:0] T_SAMPLE = TW'(UART_MID_TICK + 1);
`else
    // Data counts start at mid start-bit, so T_LAST lands mid data bit.
    localparam logic [TW-1:0] T_SAMPLE = TW'(UART_TICKS_PER_BIT - 1);
`endif

    logic          rx_meta_q;
    logic          rxs_q;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;
    logic [BW-1:0] bit_q;
    logic [BW-1:0] bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          fe_q;
    logic          fe_d;
    logic          overrun_q;
    logic          overrun_d;
    logic          tick;
    logic          bit_val;
    logic          push;
    logic          pop;
    logic          drop;
    logic          empty;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] smp_q;
    logic [1:0] smp_d;

    // Collect the two early samples of each bit window for the vote.
    always_comb begin
        smp_d = smp_q;
        if (tick && (tcnt_q == T_SAMPLE - 2'd2 || tcnt_q == T_SAMPLE - 2'd1)) begin
            smp_d = {smp_q[0], rxs_q};
        end
        bit_val = maj3(smp_q[1], smp_q[0], rxs_q);
    end

    // Vote sample history.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            smp_q <= 2'b11;
        end else begin
            smp_q <= smp_d;
        end
    end
`else
    // Single sample straight from the synchronised line.
    always_comb begin
        bit_val = rxs_q;
    end
`endif

    // Prescaler: count 0..PRESCALE and fire one tick on the wrap cycle.
    always_comb begin
        tick   = (pcnt_q == P_LAST);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    // Receiver FSM; only ever advances on a sample tick.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_d    = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_d = ST_START;
                        tcnt_d  = '0;
                    end
                end
                ST_START: begin
                    tcnt_d = tcnt_q + 1'b1;
`ifdef UART_RX_MAJORITY_EN
                    if (tcnt_q == T_SAMPLE && bit_val) begin
                        state_d = ST_IDLE;
                    end else if (tcnt_q == T_LAST) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end
`else
                    if (tcnt_q == T_MID) begin
                        if (bit_val) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            tcnt_d  = '0;
                            bit_d   = '0;
                        end
                    end
`endif
                end
                ST_DATA: begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == T_SAMPLE) begin
                        shift_d = {bit_val, shift_q[7:1]};
                    end
                    if (tcnt_q == T_LAST) begin
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == T_SAMPLE) begin
                        if (bit_val) begin
                            push    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = ST_BRK;
                        end
                    end
                end
                ST_BRK: begin
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun; a fresh drop outranks a clear in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Synchroniser, timing and FSM state registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            pcnt_q    <= '0;
            state_q   <= ST_IDLE;
            tcnt_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            fe_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rxs_q     <= rx_meta_q;
            pcnt_q    <= pcnt_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            fe_q      <= fe_d;
            overrun_q <= overrun_d;
        end
    end

    assign pop       = rd_ready;
    assign rd_valid  = !empty;
    assign frame_err = fe_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != ST_IDLE);

    uart_byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .rd_data   (rd_data),
        .empty     (empty),
        .level     (level),
        .drop      (drop)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven at nominal baud,
// FIFO contents and flags compared with a queue-based model.
module tb_uart_rx_fifo;

    localparam int PRESCALE = 4;
    localparam int FIFO_AW  = 3;
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int TICKC    = PRESCALE + 1;
    localparam int BITC     = 16 * TICKC;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic             RX = 1'b1;
    logic             rd_ready = 1'b0;
    logic             overrun_clr = 1'b0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [FIFO_AW:0] level;
    logic             frame_err;
    logic             overrun;
    logic             rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int lvl_chg_cyc = 0;
    int start_cyc = 0;
    int lat = 0;
    int fe0 = 0;
    logic [FIFO_AW:0] lvl_prev = '0;

    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;

    uart_rx_fifo #(
        .PRESCALE (PRESCALE),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .RX          (RX),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .rx_busy     (rx_busy)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
        if (level !== lvl_prev) lvl_chg_cyc = cyc;
        lvl_prev = level;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic align();
        do step(1); while (cyc % TICKC != 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        align();
        start_cyc = cyc;
        RX = 1'b0;
        step(BITC);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            step(BITC);
        end
        RX = stop;
        step(BITC);
    endtask

    task automatic mpush(input logic [7:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".level"}, 32'(level), 32'(mq.size()));
        check({tag, ".valid"}, 32'(rd_valid), 32'(mq.size() != 0));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        if (mq.size() != 0) check({tag, ".head"}, 32'(rd_data), 32'(mq[0]));
    endtask

    task automatic pop_chk(input string tag);
        check({tag, ".pop_valid"}, 32'(rd_valid), 32'd1);
        check({tag, ".pop_data"}, 32'(rd_data), 32'(mq[0]));
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
        void'(mq.pop_front());
    endtask

    initial begin
        step(4);
        HRESETn = 1'b1;
        step(2);
        check("rst.valid", 32'(rd_valid), 32'd0);
        check("rst.level", 32'(level), 32'd0);
        check("rst.fe", 32'(frame_err), 32'd0);
        check("rst.ovr", 32'(overrun), 32'd0);
        check("rst.busy", 32'(rx_busy), 32'd0);

        send_frame(8'hA5, 1'b1);
        step(20);
        mpush(8'hA5);
        check_state("t1");
        check("t1.fe", 32'(fe_cnt), 32'd0);
        check("t1.busy", 32'(rx_busy), 32'd0);
        lat = lvl_chg_cyc - start_cyc;
        check("t1.latency_range", 32'(lat > 700 && lat < 820), 32'd1);
        pop_chk("t1");

        align();
        RX = 1'b0;
        step(3 * TICKC);
        check("t2.busy_glitch", 32'(rx_busy), 32'd1);
        RX = 1'b1;
        step(BITC);
        check("t2.busy_idle", 32'(rx_busy), 32'd0);
        check("t2.level", 32'(level), 32'd0);
        check("t2.fe", 32'(fe_cnt), 32'd0);

        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        step(20);
        check("t3.fe_once", 32'(fe_cnt - fe0), 32'd1);
        check("t3.level", 32'(level), 32'd0);
        check("t3.busy_brk", 32'(rx_busy), 32'd1);
        step(40 * BITC);
        RX = 1'b1;
        step(BITC);
        check("t3.busy_rel", 32'(rx_busy), 32'd0);
        send_frame(8'h11, 1'b1);
        step(20);
        mpush(8'h11);
        check_state("t3");
        check("t3.fe_total", 32'(fe_cnt - fe0), 32'd1);
        pop_chk("t3");

        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1);
            step(20);
            mpush(8'(i));
            if (i == DEPTH - 1) check("t4.no_ovr_full", 32'(overrun), 32'd0);
        end
        check_state("t4");
        for (int i = 0; i < DEPTH; i++) pop_chk("t4");
        check("t4.empty", 32'(rd_valid), 32'd0);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        m_ovr = 1'b0;
        check("t4.ovr_clr", 32'(overrun), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, 1'b1);
            step(20);
            mpush(b);
        end
        check_state("t5.full");
        if (lat < 2) lat = 2;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                @(negedge RX);
                #1;
                step(lat - 1);
                check("t5.head_at_push", 32'(rd_data), 32'(mq[0]));
                rd_ready = 1'b1;
                step(1);
                rd_ready = 1'b0;
            end
        join
        void'(mq.pop_front());
        mq.push_back(8'h5A);
        step(20);
        check_state("t5");
        for (int i = 0; i < DEPTH; i++) pop_chk("t5");
        check("t5.drained", 32'(level), 32'd0);

        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            int k;
            b = 8'($urandom);
            send_frame(b, 1'b1);
            step($urandom_range(20, 60));
            mpush(b);
            check_state("rnd");
            k = $urandom_range(0, 1);
            for (int j = 0; j < k && mq.size() != 0; j++) pop_chk("rnd");
        end
        check("rnd.fe", 32'(fe_cnt), 32'd1);

        send_frame(8'h77, 1'b1);
        step(20);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(negedge RX);
                #1;
                step(5 * BITC + BITC / 2);
                HRESETn = 1'b0;
                step(2);
                HRESETn = 1'b1;
            end
        join
        step(2);
        mq.delete();
        m_ovr = 1'b0;
        check_state("t6.rst");
        check("t6.busy", 32'(rx_busy), 32'd0);
        check("t6.fe", 32'(frame_err), 32'd0);
        send_frame(8'h42, 1'b1);
        step(20);
        mpush(8'h42);
        check_state("t6");
        check("t6.data", 32'(rd_data), 32'h42);
        check("t6.level1", 32'(level), 32'd1);
        check("end.fe_total", 32'(fe_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
